// File: rtl/alu_pkg.sv
// Opcode encodings shared by the ALU datapath, its interface and the top level.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_NOT = 3'b111;

    typedef enum logic [2:0] {
        AluAdd = OP_ADD,
        AluSub = OP_SUB,
        AluAnd = OP_AND,
        AluOr  = OP_OR,
        AluXor = OP_XOR,
        AluShl = OP_SHL,
        AluShr = OP_SHR,
        AluNot = OP_NOT
    } alu_op_t;

endpackage

// File: rtl/alu_if.sv
// Operand/opcode/enable bundle in, registered result and flags out.
interface alu_if #(
    parameter int unsigned N = 8
);
    logic         en;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [2:0]   op_code;
    logic [N-1:0] result_out;
    logic         flag_carry;
    logic         flag_zero;

    modport master (
        output en, A, B, op_code,
        input  result_out, flag_carry, flag_zero
    );

    modport slave (
        input  en, A, B, op_code,
        output result_out, flag_carry, flag_zero
    );
endinterface

// File: rtl/alu_core.sv
// Purely combinational ALU datapath: opcode decode, (N+1)-bit add/sub and shifts with carry-out.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [2:0]   op,
    output logic [N-1:0] res,
    output logic         carry
);

    localparam int unsigned SW = (N > 1) ? $clog2(N) : 1;

    logic [SW-1:0] shamt;
    logic [N:0]    sum_ext;
    logic [N:0]    diff_ext;
    logic [N:0]    shl_ext;
    logic [N:0]    shr_ext;

    assign shamt    = B[SW-1:0];
    assign sum_ext  = {1'b0, A} + {1'b0, B};
    // Bit N of the extended difference is set exactly when A < B.
    assign diff_ext = {1'b0, A} - {1'b0, B};
    // Extra bit above/below A catches the last bit shifted out; it stays 0 for a zero shift.
    assign shl_ext  = {1'b0, A} << shamt;
    assign shr_ext  = {A, 1'b0} >> shamt;

    always_comb begin
        res   = '0;
        carry = 1'b0;
        unique case (op)
            OP_ADD: {carry, res} = sum_ext;
            OP_SUB: {carry, res} = diff_ext;
            OP_AND: res = A & B;
            OP_OR:  res = A | B;
            OP_XOR: res = A ^ B;
            OP_SHL: {carry, res} = shl_ext;
            OP_SHR: {res, carry} = shr_ext;
            OP_NOT: res = ~A;
            default: begin
                res   = '0;
                carry = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu.sv
// Registered ALU: core datapath plus enabled output register with synchronous active-low reset.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input logic clk,
    input logic rst_n,
    alu_if.slave bus
);

    logic [N-1:0] core_res;
    logic         core_carry;
    logic         core_zero;

    alu_core #(
        .N (N)
    ) u_core (
        .A     (bus.A),
        .B     (bus.B),
        .op    (bus.op_code),
        .res   (core_res),
        .carry (core_carry)
    );

    assign core_zero = (core_res == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.result_out <= '0;
            bus.flag_carry <= 1'b0;
            bus.flag_zero  <= 1'b0;
        end else if (bus.en) begin
            bus.result_out <= core_res;
            bus.flag_carry <= core_carry;
            bus.flag_zero  <= core_zero;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: driver pushes model predictions, monitor pops and compares each cycle.
module tb_alu;
    import alu_pkg::*;

    localparam int N = 8;

    typedef struct {
        longint unsigned res;
        bit              carry;
        bit              zero;
        string           tag;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   passed;
    exp_t exp_q[$];

    longint unsigned m_res;
    bit              m_carry;
    bit              m_zero;

    alu_if #(.N(N)) bus ();

    alu #(
        .N (N)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference computed with plain unsigned integer arithmetic.
    function automatic void ref_op(input int op, input longint unsigned a, input longint unsigned b,
                                   output longint unsigned r, output bit c);
        longint unsigned m;
        longint unsigned s;
        m = longint'(1) << N;
        s = b % (longint'(1) << $clog2(N));
        r = 0;
        c = 0;
        case (op)
            0: begin r = (a + b) % m; c = (a + b) >= m; end
            1: begin r = (a + m - b) % m; c = a < b; end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: begin
                r = (a * (longint'(1) << s)) % m;
                c = (s == 0) ? 1'b0 : bit'((a / (longint'(1) << (N - s))) % 2);
            end
            6: begin
                r = a / (longint'(1) << s);
                c = (s == 0) ? 1'b0 : bit'((a / (longint'(1) << (s - 1))) % 2);
            end
            default: r = (m - 1) - a;
        endcase
    endfunction

    task automatic step(input bit rst_v, input bit en_v, input int op, input longint unsigned a,
                        input longint unsigned b, input string tag);
        exp_t e;
        @(negedge clk);
        rst_n       = rst_v;
        bus.en      = en_v;
        bus.op_code = op[2:0];
        bus.A       = a[N-1:0];
        bus.B       = b[N-1:0];
        if (!rst_v) begin
            m_res   = 0;
            m_carry = 0;
            m_zero  = 0;
        end else if (en_v) begin
            ref_op(op, a % 256, b % 256, m_res, m_carry);
            m_zero = (m_res == 0);
        end
        e.res   = m_res;
        e.carry = m_carry;
        e.zero  = m_zero;
        e.tag   = tag;
        exp_q.push_back(e);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (bus.result_out !== e.res[N-1:0] || bus.flag_carry !== e.carry
                || bus.flag_zero !== e.zero) begin
                $display("FAIL %s: got result=%0h carry=%b zero=%b, expected result=%0h carry=%b zero=%b",
                         e.tag, bus.result_out, bus.flag_carry, bus.flag_zero,
                         e.res[N-1:0], e.carry, e.zero);
            end else begin
                passed++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        checks      = 0;
        passed      = 0;
        rst_n       = 1'b0;
        bus.en      = 1'b1;
        bus.op_code = 3'd0;
        bus.A       = 8'h5A;
        bus.B       = 8'hA5;

        step(0, 1, 0, 8'hFF, 8'h01, "reset0");
        step(0, 1, 5, 8'h81, 8'h01, "reset1");

        step(1, 1, 0, 250, 6, "add_overflow");
        step(1, 1, 0, 100, 27, "add_plain");
        step(1, 1, 1, 2, 3, "sub_borrow");
        step(1, 1, 1, 9, 9, "sub_equal");
        step(1, 1, 2, 23, 20, "and");
        step(1, 1, 3, 25, 0, "or");
        step(1, 1, 4, 8'hFF, 8'hFF, "xor_zero");
        step(1, 1, 7, 8'h0F, 8'h33, "not");
        step(1, 1, 5, 15, 3, "shl3");
        step(1, 1, 5, 8'h81, 1, "shl1_carry");
        step(1, 1, 6, 8'h81, 1, "shr1_carry");
        step(1, 1, 5, 8'h81, 0, "shl0");
        step(1, 1, 6, 8'h81, 8'hF8, "shr_upper_b_ignored");
        step(1, 1, 5, 8'h81, 7, "shl7");

        step(1, 1, 0, 100, 27, "hold_setup");
        for (int i = 0; i < 3; i++)
            step(1, 0, $urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 255), "hold");
        step(1, 1, 1, 50, 8, "hold_release");

        step(0, 1, 0, 1, 1, "mid_reset");
        step(1, 0, 0, 1, 1, "after_reset_idle");
        step(1, 1, 3, 8'h0C, 8'h30, "after_reset_fresh");

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 19) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 7),
                 $urandom_range(0, 255), $urandom_range(0, 255), "random");
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
